// File: rtl/world_pkg.sv
// Shared types and helpers for the grid-world engine: headings, cell codes and
// neighbour arithmetic on 1-based grid coordinates.
package world_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'b00,
    SOUTH = 2'b01,
    EAST  = 2'b10,
    WEST  = 2'b11
  } orient_t;

  localparam logic [2:0] CELL_FREE  = 3'd0;
  localparam logic [2:0] CELL_WALL  = 3'd1;
  localparam logic [2:0] CELL_TRASH = 3'd2;
  localparam logic [2:0] CELL_DIRT  = 3'd7;

  typedef struct packed {
    logic       in_grid;
    logic [5:0] row;
    logic [5:0] col;
  } coord_t;

  function automatic orient_t turn_left(input orient_t o);
    orient_t r;
    case (o)
      NORTH:   r = WEST;
      WEST:    r = SOUTH;
      SOUTH:   r = EAST;
      default: r = NORTH;
    endcase
    return r;
  endfunction

  // Range tests use the current coordinate, so the wrapped value is never trusted
  function automatic coord_t neighbour(input logic [5:0] row, input logic [5:0] col,
                                       input orient_t dir, input int rows, input int cols);
    coord_t n;
    n.in_grid = 1'b0;
    n.row     = row;
    n.col     = col;
    case (dir)
      NORTH:   begin n.in_grid = (row > 6'd1);        n.row = row - 6'd1; end
      SOUTH:   begin n.in_grid = (int'(row) < rows);  n.row = row + 6'd1; end
      EAST:    begin n.in_grid = (int'(col) < cols);  n.col = col + 6'd1; end
      default: begin n.in_grid = (col > 6'd1);        n.col = col - 6'd1; end
    endcase
    return n;
  endfunction

  function automatic int cell_index(input logic [5:0] row, input logic [5:0] col, input int cols);
    return (int'(row) - 1) * cols + int'(col) - 1;
  endfunction

endpackage

// File: rtl/world_sensors.sv
// Combinational sensor view of the robot: turns the pose into three map
// addresses and turns the three cells read back into the four sensor bits.
module world_sensors
  import world_pkg::*;
#(
  parameter int ROWS   = 10,
  parameter int COLS   = 20,
  parameter int ADDR_W = 8
) (
  input  logic [5:0]        row,
  input  logic [5:0]        col,
  input  orient_t           orient,
  input  logic [2:0]        cell_here,
  input  logic [2:0]        cell_ahead,
  input  logic [2:0]        cell_left,
  output logic [ADDR_W-1:0] addr_here,
  output logic [ADDR_W-1:0] addr_ahead,
  output logic [ADDR_W-1:0] addr_left,
  output logic              head,
  output logic              left,
  output logic              under,
  output logic              barrier
);

  coord_t ahead_pos;
  coord_t left_pos;

  // Off-grid neighbours read cell 0; their value is masked by the in-grid flag
  always_comb begin
    ahead_pos  = neighbour(row, col, orient, ROWS, COLS);
    left_pos   = neighbour(row, col, turn_left(orient), ROWS, COLS);
    addr_here  = ADDR_W'(cell_index(row, col, COLS));
    addr_ahead = ahead_pos.in_grid ? ADDR_W'(cell_index(ahead_pos.row, ahead_pos.col, COLS)) : '0;
    addr_left  = left_pos.in_grid ? ADDR_W'(cell_index(left_pos.row, left_pos.col, COLS)) : '0;
    head       = !ahead_pos.in_grid || (cell_ahead == CELL_WALL);
    left       = !left_pos.in_grid || (cell_left == CELL_WALL);
    under      = (cell_here == CELL_DIRT);
    barrier    = ahead_pos.in_grid && (cell_ahead == CELL_TRASH);
  end

endmodule

// File: rtl/world_engine.sv
// Grid-world engine: owns the cell map and robot pose, paces the robot with a
// one-cycle tick per step and applies its moves and trash removals.
module world_engine
  import world_pkg::*;
#(
  parameter int ROWS         = 10,
  parameter int COLS         = 20,
  parameter int STEP_DIV     = 4,
  parameter int REMOVE_STEPS = 3,
  parameter int ADDR_W       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  input  logic              start,
  input  logic [5:0]        start_row,
  input  logic [5:0]        start_col,
  input  logic [1:0]        start_orient,
  input  logic              stop,
  input  logic              front,
  input  logic              turn,
  input  logic              remove,
  output logic              head,
  output logic              left,
  output logic              under,
  output logic              barrier,
  output logic              robot_tick,
  output logic [5:0]        robot_row,
  output logic [5:0]        robot_column,
  output logic [1:0]        robot_orientation,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        rd_data,
  output logic [7:0]        removed_count,
  output logic              running,
  output logic              error
);

  localparam int CELLS    = ROWS * COLS;
  localparam int HOLD_W   = $clog2(STEP_DIV);
  localparam int STREAK_W = $clog2(REMOVE_STEPS + 1);

  typedef enum logic [2:0] {IDLE, SENSE, TICK, APPLY, HOLD} state_t;

  state_t              state;
  orient_t             orient;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STREAK_W-1:0] streak;
  logic [2:0]          map_mem [CELLS];
  logic [ADDR_W-1:0]   addr_here, addr_ahead, addr_left;
  logic                sense_head, sense_left, sense_under, sense_barrier;
  logic                map_we;
  logic [ADDR_W-1:0]   map_waddr;
  logic [2:0]          map_wdata;
  logic                start_ok;
  logic                clear_now;
  coord_t              ahead_pos;

  world_sensors #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) u_sensors (
    .row       (robot_row),
    .col       (robot_column),
    .orient    (orient),
    .cell_here (map_mem[addr_here]),
    .cell_ahead(map_mem[addr_ahead]),
    .cell_left (map_mem[addr_left]),
    .addr_here (addr_here),
    .addr_ahead(addr_ahead),
    .addr_left (addr_left),
    .head      (sense_head),
    .left      (sense_left),
    .under     (sense_under),
    .barrier   (sense_barrier)
  );

  assign running           = (state != IDLE);
  assign robot_orientation = orient;
  assign ahead_pos         = neighbour(robot_row, robot_column, orient, ROWS, COLS);
  assign start_ok          = (start_row != 6'd0) && (int'(start_row) <= ROWS) &&
                             (start_col != 6'd0) && (int'(start_col) <= COLS);
  assign clear_now         = (state == APPLY) && !stop && remove && barrier &&
                             (streak == STREAK_W'(REMOVE_STEPS - 1));

  // The single map write port is shared by the IDLE loader and trash clearing
  always_comb begin
    map_we    = 1'b0;
    map_waddr = wr_addr;
    map_wdata = wr_data;
    if (state == IDLE) begin
      map_we = wr_en && (int'(wr_addr) < CELLS);
    end else if (clear_now) begin
      map_we    = 1'b1;
      map_waddr = addr_ahead;
      map_wdata = CELL_FREE;
    end
  end

  always_ff @(posedge clock) begin
    if (map_we) map_mem[map_waddr] <= map_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= CELL_FREE;
    else       rd_data <= (int'(rd_addr) < CELLS) ? map_mem[rd_addr] : CELL_FREE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      robot_row     <= 6'd1;
      robot_column  <= 6'd1;
      orient        <= NORTH;
      head          <= 1'b0;
      left          <= 1'b0;
      under         <= 1'b0;
      barrier       <= 1'b0;
      robot_tick    <= 1'b0;
      removed_count <= 8'd0;
      streak        <= '0;
      hold_cnt      <= '0;
      error         <= 1'b0;
    end else begin
      robot_tick <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (start_ok) begin
            robot_row    <= start_row;
            robot_column <= start_col;
            orient       <= orient_t'(start_orient);
            error        <= 1'b0;
            state        <= SENSE;
          end else begin
            error <= 1'b1;
          end
        end
      end else if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          SENSE: begin
            head       <= sense_head;
            left       <= sense_left;
            under      <= sense_under;
            barrier    <= sense_barrier;
            robot_tick <= 1'b1;
            state      <= TICK;
          end
          TICK: state <= APPLY;
          APPLY: begin
            if (remove) begin
              if (!barrier) begin
                streak <= '0;
              end else if (clear_now) begin
                streak <= '0;
                if (removed_count != 8'hFF) removed_count <= removed_count + 8'd1;
              end else begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
              if (front) begin
                if (head || !ahead_pos.in_grid) begin
                  error <= 1'b1;
                end else begin
                  robot_row    <= ahead_pos.row;
                  robot_column <= ahead_pos.col;
                end
              end else if (turn) begin
                orient <= turn_left(orient);
              end
            end
            if (STEP_DIV == 3) begin
              state <= SENSE;
            end else begin
              hold_cnt <= HOLD_W'(STEP_DIV - 4);
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) state <= SENSE;
            else                hold_cnt <= hold_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_world_engine.sv
// Bench for world_engine: directed scenarios plus a randomized walk, all
// checked against a plain array-based model of the grid world.
`timescale 1ns/1ps
module tb_world_engine;

  localparam int ROWS = 10, COLS = 20, STEP_DIV = 4, REMOVE_STEPS = 3, ADDR_W = 8;
  localparam int B_ROWS = 4, B_COLS = 7, B_STEP = 5, B_ADDR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0, start = 1'b0, stop = 1'b0, front = 1'b0, turn = 1'b0, remove = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [2:0] wr_data = '0, rd_data;
  logic [5:0] start_row = '0, start_col = '0, robot_row, robot_column;
  logic [1:0] start_orient = '0, robot_orientation;
  logic head, left, under, barrier, robot_tick, running, error;
  logic [7:0] removed_count;

  logic b_wr_en = 1'b0, b_start = 1'b0, b_stop = 1'b0, b_front = 1'b0, b_turn = 1'b0, b_remove = 1'b0;
  logic [B_ADDR_W-1:0] b_wr_addr = '0, b_rd_addr = '0;
  logic [2:0] b_wr_data = '0, b_rd_data;
  logic [5:0] b_start_row = '0, b_start_col = '0, b_robot_row, b_robot_column;
  logic [1:0] b_start_orient = '0, b_robot_orientation;
  logic b_head, b_left, b_under, b_barrier, b_robot_tick, b_running, b_error;
  logic [7:0] b_removed_count;

  world_engine #(.ROWS(ROWS), .COLS(COLS), .STEP_DIV(STEP_DIV), .REMOVE_STEPS(REMOVE_STEPS)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_row(start_row), .start_col(start_col), .start_orient(start_orient),
    .stop(stop), .front(front), .turn(turn), .remove(remove),
    .head(head), .left(left), .under(under), .barrier(barrier), .robot_tick(robot_tick),
    .robot_row(robot_row), .robot_column(robot_column), .robot_orientation(robot_orientation),
    .rd_addr(rd_addr), .rd_data(rd_data), .removed_count(removed_count),
    .running(running), .error(error)
  );

  world_engine #(.ROWS(B_ROWS), .COLS(B_COLS), .STEP_DIV(B_STEP), .REMOVE_STEPS(1)) dut_b (
    .clock(clock), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .start(b_start), .start_row(b_start_row), .start_col(b_start_col), .start_orient(b_start_orient),
    .stop(b_stop), .front(b_front), .turn(b_turn), .remove(b_remove),
    .head(b_head), .left(b_left), .under(b_under), .barrier(b_barrier), .robot_tick(b_robot_tick),
    .robot_row(b_robot_row), .robot_column(b_robot_column), .robot_orientation(b_robot_orientation),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .removed_count(b_removed_count),
    .running(b_running), .error(b_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // Reference world: headings indexed north, south, east, west
  int grid [ROWS][COLS];
  int m_row = 1, m_col = 1, m_or = 0, m_err = 0, m_count = 0, m_streak = 0;
  bit m_head, m_left, m_under, m_barrier;
  int dr [4] = '{-1, 1, 0, 0};
  int dc [4] = '{0, 0, 1, -1};
  int leftof [4] = '{3, 2, 0, 1};
  int last_tick = 0;
  bit tick_seen = 1'b0;

  function automatic int cell_at(int r, int c);
    if (r < 1 || r > ROWS || c < 1 || c > COLS) return -1;
    return grid[r-1][c-1];
  endfunction

  task automatic model_sense();
    int a = cell_at(m_row + dr[m_or], m_col + dc[m_or]);
    int l = cell_at(m_row + dr[leftof[m_or]], m_col + dc[leftof[m_or]]);
    m_head    = (a < 0) || (a == 1);
    m_left    = (l < 0) || (l == 1);
    m_under   = (grid[m_row-1][m_col-1] == 7);
    m_barrier = (a == 2);
  endtask

  task automatic model_apply(input bit f, input bit t, input bit r);
    if (r) begin
      if (m_barrier) begin
        m_streak++;
        if (m_streak == REMOVE_STEPS) begin
          grid[m_row-1+dr[m_or]][m_col-1+dc[m_or]] = 0;
          if (m_count < 255) m_count++;
          m_streak = 0;
        end
      end else m_streak = 0;
    end else begin
      m_streak = 0;
      if (f) begin
        if (m_head) m_err = 1;
        else begin m_row += dr[m_or]; m_col += dc[m_or]; end
      end else if (t) m_or = leftof[m_or];
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pose(input string tag);
    check_output({tag, "_row"}, robot_row, m_row);
    check_output({tag, "_col"}, robot_column, m_col);
    check_output({tag, "_orient"}, robot_orientation, m_or);
    check_output({tag, "_error"}, error, m_err);
    check_output({tag, "_count"}, removed_count, m_count);
  endtask

  task automatic write_cell(input int r, input int c, input int v);
    grid[r-1][c-1] = v;
    wr_en = 1'b1; wr_addr = ADDR_W'((r-1)*COLS + c-1); wr_data = 3'(v);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic load_map();
    for (int r = 1; r <= ROWS; r++)
      for (int c = 1; c <= COLS; c++) write_cell(r, c, grid[r-1][c-1]);
  endtask

  task automatic vga_read(input string tag, input int r, input int c);
    rd_addr = ADDR_W'((r-1)*COLS + c-1);
    @(negedge clock);
    check_output(tag, rd_data, grid[r-1][c-1]);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (robot_tick !== 1'b1 && n < 3*STEP_DIV) begin @(negedge clock); n++; end
    check_output({tag, "_tick_seen"}, robot_tick, 1);
    if (tick_seen) check_output({tag, "_period"}, cyc - last_tick, STEP_DIV);
    tick_seen = 1'b1;
    last_tick = cyc;
  endtask

  task automatic start_run(input int r, input int c, input int o);
    bit ok = (r >= 1 && r <= ROWS && c >= 1 && c <= COLS);
    start_row = 6'(r); start_col = 6'(c); start_orient = 2'(o); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    tick_seen = 1'b0;
    if (ok) begin
      m_row = r; m_col = c; m_or = o; m_err = 0;
      check_output("start_running", running, 1);
      check_output("start_no_tick_in_sense", robot_tick, 0);
      @(negedge clock);
      check_output("start_first_tick", robot_tick, 1);
    end else begin
      m_err = 1;
      check_output("badstart_running", running, 0);
      check_output("badstart_error", error, 1);
    end
  endtask

  task automatic apply_stimulus(input bit f, input bit t, input bit r);
    wait_tick("step");
    model_sense();
    check_output("sense_head", head, m_head);
    check_output("sense_left", left, m_left);
    check_output("sense_under", under, m_under);
    check_output("sense_barrier", barrier, m_barrier);
    front = f; turn = t; remove = r;
    @(negedge clock);
    @(negedge clock);
    front = 1'b0; turn = 1'b0; remove = 1'b0;
    model_apply(f, t, r);
    check_output("step_running", running, 1);
    check_pose("step");
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_output("stop_running", running, 0);
    check_pose("stop");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p, sel;
    bit rf, rt, rr;
    @(negedge clock);
    @(negedge clock);
    check_output("rst_head", head, 0);
    check_output("rst_left", left, 0);
    check_output("rst_under", under, 0);
    check_output("rst_barrier", barrier, 0);
    check_output("rst_tick", robot_tick, 0);
    check_output("rst_running", running, 0);
    check_output("rst_rd_data", rd_data, 0);
    check_pose("rst");
    check_output("rst_b_row", b_robot_row, 1);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed scenarios");
    foreach (grid[i, j]) grid[i][j] = 0;
    grid[3][4] = 2;
    grid[2][2] = 7;
    load_map();

    rd_addr = ADDR_W'(ROWS*COLS - 1);
    wr_en = 1'b1; wr_addr = ADDR_W'(ROWS*COLS - 1); wr_data = 3'd4;
    @(negedge clock);
    wr_en = 1'b0;
    check_output("rw_same_addr_old", rd_data, 0);
    grid[ROWS-1][COLS-1] = 4;
    vga_read("rw_same_addr_new", ROWS, COLS);

    start_run(5, 5, 0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1);
    stop_run();
    vga_read("trash_cleared", 4, 5);

    write_cell(4, 5, 2);
    start_run(5, 5, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    stop_run();
    vga_read("trash_kept", 4, 5);

    start_run(5, 5, 2);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    stop_run();
    start_run(5, 5, 2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    stop_run();

    start_run(3, 2, 2);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    stop_run();

    start_run(1, 1, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    stop_run();

    start_run(10, 20, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    stop_run();
    start_run(11, 3, 0);
    start_run(2, 2, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    stop_run();
    start_run(3, 0, 0);
    vga_read("vga_dirt", 3, 3);

    $display("[TB] randomized walk");
    foreach (grid[i, j]) begin
      p = $urandom_range(0, 99);
      grid[i][j] = (p < 55) ? 0 : (p < 70) ? 1 : (p < 82) ? 2 : (p < 92) ? 7 : $urandom_range(3, 6);
    end
    load_map();
    start_run($urandom_range(1, ROWS), $urandom_range(1, COLS), $urandom_range(0, 3));
    for (int k = 0; k < 60; k++) begin
      model_sense();
      rr = m_barrier ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 4) == 0);
      rf = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      apply_stimulus(rf, rt, rr);
      sel = k % 7;
      if (sel == 3) begin
        wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(0, ROWS*COLS-1)); wr_data = 3'($urandom_range(0, 7));
        @(negedge clock);
        wr_en = 1'b0;
      end else if (sel == 5) begin
        start_row = 6'd1; start_col = 6'd1; start_orient = 2'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    end
    stop_run();
    for (int r = 1; r <= ROWS; r++)
      for (int c = 1; c <= COLS; c++) vga_read("map_readback", r, c);

    $display("[TB] small grid");
    for (int i = 0; i < B_ROWS*B_COLS; i++) begin
      b_wr_en = 1'b1; b_wr_addr = B_ADDR_W'(i); b_wr_data = 3'd0;
      @(negedge clock);
    end
    b_wr_en = 1'b0;
    b_start_row = 6'd4; b_start_col = 6'd7; b_start_orient = 2'd1; b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    for (int n = 0; n < 3*B_STEP && b_robot_tick !== 1'b1; n++) @(negedge clock);
    check_output("b_tick_seen", b_robot_tick, 1);
    check_output("b_head", b_head, 1);
    check_output("b_left", b_left, 1);
    @(negedge clock);
    @(negedge clock);
    check_output("b_in_hold", b_running, 1);
    b_stop = 1'b1;
    @(negedge clock);
    b_stop = 1'b0;
    check_output("b_stop_running", b_running, 0);
    check_output("b_stop_row", b_robot_row, 4);
    check_output("b_stop_col", b_robot_column, 7);
    check_output("b_stop_orient", b_robot_orientation, 1);
    @(negedge clock);
    check_output("b_no_tick_idle", b_robot_tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/world_engine.md
# world_engine

Parametrised grid-world engine for the pipe-cleaning robot. It holds a ROWS×COLS cell map and the robot pose, and paces the robot with a one-cycle `robot_tick` enable once per step. Each step it drives the four sensor inputs, then applies the robot's `front`/`turn`/`remove` outputs to the pose and the map. It sits between the `robot` FSM and the VGA graphics block, which reads the map through a dedicated port.

## Interface
- `ROWS`, 10, grid rows, 1..63
- `COLS`, 20, grid columns, 1..63
- `STEP_DIV`, 4, clock cycles per robot step, ≥3
- `REMOVE_STEPS`, 3, consecutive `remove` steps needed to clear a trash cell, ≥1
- `clock` in 1 — single clock
- `reset` in 1 — asynchronous, active-high
- `wr_en`, `wr_addr`, `wr_data` in 1, ADDR_W, 3 — map load port, honoured only in IDLE
- `start` in 1 — pulse; leaves IDLE, loads the pose from `start_row`, `start_col`, `start_orient` (6, 6, 2)
- `stop` in 1 — return to IDLE
- `front`, `turn`, `remove` in 1 each — from the robot
- `head`, `left`, `under`, `barrier` out 1 each — registered sensors to the robot
- `robot_tick` out 1 — robot clock enable
- `robot_row`, `robot_column` out 6 each — 1-based pose
- `robot_orientation` out 2 — current heading
- `rd_addr` in ADDR_W, `rd_data` out 3 — VGA read port
- `removed_count` out 8 — number of trash cells cleared
- `running`, `error` out 1 each — status

ADDR_W = $clog2(ROWS*COLS). Cell address = (row−1)*COLS + (col−1).

## Operation
- Cell codes: 0 free, 1 wall, 2 trash, 7 dirt; any other code is treated as free.
- States: IDLE → SENSE → TICK → APPLY → HOLD (STEP_DIV−3 cycles; skipped when STEP_DIV=3) → SENSE …
- IDLE: the map is writable. On `start`, if the start pose is in range, load the pose and go to SENSE. If it is out of range, set `error` and stay in IDLE.
- SENSE: register the sensors from the current pose.
  - `head` = facing the grid edge, or the cell ahead == 1.
  - `left` = grid edge on the left side, or the left cell == 1.
  - `under` = own cell == 7.
  - `barrier` = cell ahead is in-grid and == 2. Off-grid is never a barrier.
  - Left of north is west, of west is south, of south is east, of east is north.
- TICK: `robot_tick`=1 for exactly one cycle. The robot outputs are valid from the next cycle.
- APPLY: priority is `remove` > `front` > `turn`.
  - `remove`=1 with `barrier`=1: increment the removal streak. When the streak reaches REMOVE_STEPS, write 0 to the cell ahead, increment `removed_count` (saturating at 255), and clear the streak.
  - `remove`=1 with `barrier`=0: clear the streak, no map write.
  - `front`=1 with `head`=0: step one cell in the heading.
  - `front`=1 with `head`=1: set `error` (sticky until reset or the next `start`). The pose does not move.
  - `turn`=1: rotate left.
  - Any non-remove action clears the streak.
- `stop` in any run state: go to IDLE next cycle. The pose and map are held and any pending write is dropped.
- `start` while running is ignored. Map writes while running are ignored.

## Timing
- Reset values: state IDLE, pose (1,1,north), all sensors 0, `robot_tick` 0, `removed_count` 0, streak 0, `running` 0, `error` 0, `rd_data` 0. Map contents are not reset.
- `running` = 1 in every state except IDLE.
- `start` to first `robot_tick`: 2 cycles (SENSE, then TICK).
- Step period is exactly STEP_DIV cycles, measured between consecutive `robot_tick` pulses.
- Pose and map updates become visible in the cycle after APPLY.
- `rd_data` is registered with 1-cycle latency. A read and a write to the same address in the same cycle return the old data.

## Structure
- `world_pkg` holds:
  - the orientation enum (north=00, south=01, east=10, west=11);
  - the cell-code constants;
  - `turn_left()`;
  - a neighbour-coordinate function with an in-grid flag.
- Sub-module `world_sensors` is combinational: pose plus three map reads in, four sensor bits out. It is instantiated once.
- The map is a ROWS*COLS×3 register array with three async reads (sensors), one registered read (VGA), and one write port.

## Test plan
- Reset: all outputs hold their reset values. With STEP_DIV=4, `start` at (5,5,north) → `robot_tick` 2 cycles later, then every 4 cycles.
- Empty map: robot at (1,1,north) → `head`=1, `left`=1. Then `front`=1 → pose unchanged and `error`=1.
- Trash at (4,5), robot at (5,5,north), `remove` for 3 steps → cell (4,5) reads 0 and `removed_count`=1. The same test with `remove` dropped at step 2 → cell stays 2.
- `front`=1 and `turn`=1 together at (5,5,east) → (5,6,east). A `turn`-only step at (5,5,east) → north.
- Dirt at (3,3) → `under`=1 while the robot is on (3,3), 0 elsewhere. A VGA read of (3,3) returns 7 one cycle later.
- Parametrised run ROWS=4, COLS=7, robot at (4,7,south) → `head`=1 and `left`=1. `stop` mid-HOLD → IDLE next cycle with the pose retained.
